// File: rtl/snr_pkg.sv
// Shared types and defaults for the SNR calibration sequencer.
package snr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CALIB   = 2'd2,
        MEASURE = 2'd3
    } snr_seq_state_t;

    localparam int SNR_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/snr_seq_counter.sv
// Accepted-sample counter shared by all sequencer states; stops at the terminal value.
module snr_seq_counter #(
    parameter int CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 terminal_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    assign terminal_o = (count_q == limit_i);

    // Next count: clear wins, otherwise advance on enable until the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_WIDTH{1'b0}};
        end else if (en_i && !terminal_o) begin
            count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/snr_calib_sequencer.sv
// Calibration sequencer for the streaming SNR estimator: SETTLE -> CALIB -> MEASURE with
// periodic recalibration and a hysteretic snr_good flag. Observes the audio handshake only.
module snr_calib_sequencer
    import snr_pkg::*;
#(
    parameter int SNR_WIDTH      = SNR_WIDTH_DEFAULT,
    parameter int CNT_WIDTH      = 20,
    parameter int SETTLE_SAMPLES = 256,
    parameter int CAL_SAMPLES    = 16384,
    parameter int BLANK_SAMPLES  = 4,
    parameter int RECAL_SAMPLES  = 480000,
    parameter int SNR_HI         = 20,
    parameter int SNR_LO         = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 audio_valid,
    input  logic                 audio_ready,
    input  logic [SNR_WIDTH-1:0] snr_db,
    input  logic                 snr_valid,
    output logic                 quiet_period,
    output logic                 calib_done,
    output logic                 cal_pulse,
    output logic                 snr_good,
    output logic                 busy,
    output logic [1:0]           state_o
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SETTLE  = SETTLE;
    localparam logic [1:0] ST_CALIB   = CALIB;
    localparam logic [1:0] ST_MEASURE = MEASURE;

    localparam int BLK_W = $clog2(BLANK_SAMPLES + 2);

    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_WIDTH-1:0] CAL_LAST    = CNT_WIDTH'(CAL_SAMPLES - 1);
    // With recal disabled the counter parks at all-ones and never triggers a transition.
    localparam logic [CNT_WIDTH-1:0] RECAL_LAST  = (RECAL_SAMPLES == 0) ? {CNT_WIDTH{1'b1}}
                                                                        : CNT_WIDTH'(RECAL_SAMPLES - 1);
    localparam logic                 RECAL_EN    = (RECAL_SAMPLES != 0);
    localparam logic [BLK_W-1:0]     BLANK_LAST  = BLK_W'(BLANK_SAMPLES);
    localparam logic [SNR_WIDTH-1:0] HI_TH       = SNR_WIDTH'(SNR_HI);
    localparam logic [SNR_WIDTH-1:0] LO_TH       = SNR_WIDTH'(SNR_LO);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [BLK_W-1:0]     blank_q;
    logic [BLK_W-1:0]     blank_d;
    logic                 quiet_q;
    logic                 calib_done_q;
    logic                 cal_pulse_q;
    logic                 snr_good_q;
    logic                 snr_good_d;
    logic                 busy_q;
    logic                 fire_s;
    logic                 terminal_s;
    logic                 cnt_clear_s;
    logic                 cal_end_s;
    logic                 blank_done_s;
    logic [CNT_WIDTH-1:0] limit_s;

    assign fire_s       = audio_valid & audio_ready;
    assign cnt_clear_s  = (state_d != state_q);
    assign cal_end_s    = (state_q == ST_CALIB) && (state_d == ST_MEASURE);
    assign blank_done_s = (blank_q == BLANK_LAST);

    // Terminal value for the shared counter in the current state.
    always_comb begin
        limit_s = {CNT_WIDTH{1'b0}};
        case (state_q)
            ST_SETTLE:  limit_s = SETTLE_LAST;
            ST_CALIB:   limit_s = CAL_LAST;
            ST_MEASURE: limit_s = RECAL_LAST;
            default:    limit_s = {CNT_WIDTH{1'b0}};
        endcase
    end

    snr_seq_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_clear_s),
        .en_i       (fire_s),
        .limit_i    (limit_s),
        .terminal_o (terminal_s)
    );

    // Sequencer next state; abort overrides start and count events.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_SETTLE;
                    else       state_d = ST_IDLE;
                end
                ST_SETTLE: begin
                    if (fire_s && terminal_s) state_d = ST_CALIB;
                    else                      state_d = ST_SETTLE;
                end
                ST_CALIB: begin
                    if (fire_s && terminal_s) state_d = ST_MEASURE;
                    else                      state_d = ST_CALIB;
                end
                ST_MEASURE: begin
                    if (RECAL_EN && fire_s && terminal_s) state_d = ST_SETTLE;
                    else                                  state_d = ST_MEASURE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Blanking counter covers the estimator pipeline latency after MEASURE entry.
    always_comb begin
        blank_d = blank_q;
        if ((state_q == ST_MEASURE) && (state_d == ST_MEASURE)) begin
            if (fire_s && !blank_done_s) blank_d = blank_q + {{(BLK_W-1){1'b0}}, 1'b1};
            else                         blank_d = blank_q;
        end else begin
            blank_d = {BLK_W{1'b0}};
        end
    end

    // Hysteresis: set at or above HI, clear at or below LO, hold in between.
    always_comb begin
        snr_good_d = snr_good_q;
        if ((state_q != ST_MEASURE) || (state_d != ST_MEASURE)) begin
            snr_good_d = 1'b0;
        end else if (blank_done_s && snr_valid) begin
            if (snr_db >= HI_TH)      snr_good_d = 1'b1;
            else if (snr_db <= LO_TH) snr_good_d = 1'b0;
            else                      snr_good_d = snr_good_q;
        end else begin
            snr_good_d = snr_good_q;
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            blank_q      <= {BLK_W{1'b0}};
            quiet_q      <= 1'b0;
            calib_done_q <= 1'b0;
            cal_pulse_q  <= 1'b0;
            snr_good_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            blank_q      <= blank_d;
            quiet_q      <= (state_d == ST_CALIB);
            calib_done_q <= calib_done_q | cal_end_s;
            cal_pulse_q  <= cal_end_s;
            snr_good_q   <= snr_good_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign quiet_period = quiet_q;
    assign calib_done   = calib_done_q;
    assign cal_pulse    = cal_pulse_q;
    assign snr_good     = snr_good_q;
    assign busy         = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_snr_calib_sequencer.sv
// Directed self-checking bench for snr_calib_sequencer with short sample counts.
module tb_snr_calib_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       audio_valid;
    logic       audio_ready;
    logic [7:0] snr_db;
    logic       snr_valid;
    logic       quiet_period;
    logic       calib_done;
    logic       cal_pulse;
    logic       snr_good;
    logic       busy;
    logic [1:0] state_o;

    int checks;
    int failures;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CALIB   = 2'd2;
    localparam logic [1:0] S_MEASURE = 2'd3;

    snr_calib_sequencer #(
        .SNR_WIDTH      (8),
        .CNT_WIDTH      (8),
        .SETTLE_SAMPLES (4),
        .CAL_SAMPLES    (8),
        .BLANK_SAMPLES  (2),
        .RECAL_SAMPLES  (16),
        .SNR_HI         (20),
        .SNR_LO         (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .audio_valid  (audio_valid),
        .audio_ready  (audio_ready),
        .snr_db       (snr_db),
        .snr_valid    (snr_valid),
        .quiet_period (quiet_period),
        .calib_done   (calib_done),
        .cal_pulse    (cal_pulse),
        .snr_good     (snr_good),
        .busy         (busy),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from SETTLE until MEASURE is reached, tallying settle fires, quiet fires and
    // cycles where quiet_period disagrees with the CALIB state; optional 10-cycle ready gap.
    task automatic run_seq(input bit gap, output int settle_n, output int quiet_n,
                           output int bad_quiet, output int pulses);
        int cyc;
        int gap_left;
        bit gapped;
        bit fire;
        cyc = 0; gap_left = 0; gapped = 1'b0;
        settle_n = 0; quiet_n = 0; bad_quiet = 0; pulses = 0;
        while (state_o != S_MEASURE && cyc < 200) begin
            if (gap && !gapped && state_o == S_CALIB && quiet_n == 4) begin
                gap_left = 10;
                gapped = 1'b1;
            end
            audio_ready = (gap_left == 0);
            fire = audio_valid && audio_ready;
            if (state_o == S_SETTLE && fire) settle_n++;
            if (quiet_period && fire) quiet_n++;
            if (quiet_period != (state_o == S_CALIB)) bad_quiet++;
            if (cal_pulse) pulses++;
            tick();
            if (gap_left > 0) gap_left--;
            cyc++;
        end
        audio_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({quiet_period, calib_done, cal_pulse, snr_good, busy, state_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {quiet_period, calib_done, cal_pulse, snr_good, busy, state_o}, 7'b0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (state_o !== S_IDLE || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got state=%0d busy=%b exp state=0 busy=0", state_o, busy);
        end
    endtask

    task automatic test_calib();
        int sn, qn, bq, pl;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || state_o !== S_SETTLE || quiet_period !== 1'b0) begin
            failures++;
            $display("FAIL start_busy got busy=%b state=%0d quiet=%b exp 1/1/0",
                     busy, state_o, quiet_period);
        end
        run_seq(1'b0, sn, qn, bq, pl);
        checks++;
        if (state_o !== S_MEASURE) begin
            failures++;
            $display("FAIL calib_timeout got state=%0d exp=3", state_o);
        end
        checks++;
        if (sn !== 4 || qn !== 8 || bq !== 0 || pl !== 0) begin
            failures++;
            $display("FAIL calib_counts got settle=%0d quiet=%0d bad=%0d pulses=%0d exp 4/8/0/0",
                     sn, qn, bq, pl);
        end
        checks++;
        if (cal_pulse !== 1'b1 || calib_done !== 1'b1 || quiet_period !== 1'b0) begin
            failures++;
            $display("FAIL calib_end got pulse=%b done=%b quiet=%b exp 1/1/0",
                     cal_pulse, calib_done, quiet_period);
        end
    endtask

    task automatic test_hysteresis();
        logic [7:0] db_vec [0:6];
        logic       exp_vec[0:6];
        db_vec  = '{8'd30, 8'd30, 8'd25, 8'd17, 8'd15, 8'd19, 8'd20};
        exp_vec = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        snr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            snr_db = db_vec[i];
            tick();
            checks++;
            if (snr_good !== exp_vec[i] || state_o !== S_MEASURE) begin
                failures++;
                $display("FAIL hyst_%0d snr_db=%0d got good=%b state=%0d exp good=%b state=3",
                         i, db_vec[i], snr_good, state_o, exp_vec[i]);
            end
            if (i == 0) begin
                checks++;
                if (cal_pulse !== 1'b0) begin
                    failures++;
                    $display("FAIL pulse_width got=%b exp=0", cal_pulse);
                end
            end
        end
        snr_valid = 1'b0;
        snr_db = 8'd5;
        for (int i = 7; i < 15; i++) tick();
        checks++;
        if (snr_good !== 1'b1 || state_o !== S_MEASURE) begin
            failures++;
            $display("FAIL hyst_hold got good=%b state=%0d exp 1/3", snr_good, state_o);
        end
        tick();
        checks++;
        if (state_o !== S_SETTLE || snr_good !== 1'b0 || calib_done !== 1'b1) begin
            failures++;
            $display("FAIL recal_entry got state=%0d good=%b done=%b exp 1/0/1",
                     state_o, snr_good, calib_done);
        end
    endtask

    task automatic test_recal_gap();
        int sn, qn, bq, pl;
        run_seq(1'b1, sn, qn, bq, pl);
        checks++;
        if (sn !== 4 || qn !== 8 || bq !== 0 || state_o !== S_MEASURE) begin
            failures++;
            $display("FAIL recal_gap got settle=%0d quiet=%0d bad=%0d state=%0d exp 4/8/0/3",
                     sn, qn, bq, state_o);
        end
        checks++;
        if (cal_pulse !== 1'b1) begin
            failures++;
            $display("FAIL second_pulse got=%b exp=1", cal_pulse);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (state_o !== S_MEASURE || busy !== 1'b1 || quiet_period !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored got state=%0d busy=%b quiet=%b exp 3/1/0",
                     state_o, busy, quiet_period);
        end
    endtask

    task automatic test_abort();
        int sn, qn, bq, pl;
        int pulses;
        abort = 1'b1;
        tick();
        checks++;
        if (state_o !== S_IDLE || busy !== 1'b0 || snr_good !== 1'b0 || calib_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_measure got state=%0d busy=%b good=%b done=%b exp 0/0/0/1",
                     state_o, busy, snr_good, calib_done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (state_o !== S_IDLE) begin
            failures++;
            $display("FAIL abort_start got state=%0d exp=0", state_o);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (state_o !== S_CALIB || quiet_period !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup got state=%0d quiet=%b exp 2/1", state_o, quiet_period);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (cal_pulse) pulses++;
            tick();
        end
        checks++;
        if (state_o !== S_IDLE || quiet_period !== 1'b0 || pulses !== 0 || calib_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_calib got state=%0d quiet=%b pulses=%0d done=%b exp 0/0/0/1",
                     state_o, quiet_period, pulses, calib_done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        run_seq(1'b0, sn, qn, bq, pl);
        checks++;
        if (sn !== 4 || qn !== 8 || cal_pulse !== 1'b1 || state_o !== S_MEASURE) begin
            failures++;
            $display("FAIL abort_rerun got settle=%0d quiet=%0d pulse=%b state=%0d exp 4/8/1/3",
                     sn, qn, cal_pulse, state_o);
        end
    endtask

    task automatic test_reset_mid_calib();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({quiet_period, calib_done, cal_pulse, snr_good, busy, state_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_calib got=%b exp=%b",
                     {quiet_period, calib_done, cal_pulse, snr_good, busy, state_o}, 7'b0);
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        audio_valid = 1'b1;
        audio_ready = 1'b1;
        snr_db = 8'd0;
        snr_valid = 1'b0;
        test_reset();
        test_calib();
        test_hysteresis();
        test_recal_gap();
        test_start_ignored();
        test_abort();
        test_reset_mid_calib();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
